// File: rtl/wb_arbiter_if.sv
// Register-file write-port arbiter bus.
// Bundles the ALU result input, the load-result handshake, the registered
// register-file write port and the status outputs.
//   master : producer side (pipeline / bench) driving alu_* and lsu_*
//   slave  : arbiter side driving lsu_ready, AD3/WE3/WD3, pending, stall_o, err_o
interface wb_arbiter_if #(
    parameter int unsigned D_WIDTH = 32,
    parameter int unsigned A_WIDTH = 5
);
    logic                    alu_valid;
    logic [A_WIDTH-1:0]      alu_rd;
    logic [D_WIDTH-1:0]      alu_data;
    logic                    lsu_valid;
    logic                    lsu_ready;
    logic [A_WIDTH-1:0]      lsu_rd;
    logic [D_WIDTH-1:0]      lsu_data;
    logic [A_WIDTH-1:0]      AD3;
    logic                    WE3;
    logic [D_WIDTH-1:0]      WD3;
    logic [2**A_WIDTH-1:0]   pending;
    logic                    stall_o;
    logic                    err_o;

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  lsu_ready, AD3, WE3, WD3, pending, stall_o, err_o
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output lsu_ready, AD3, WE3, WD3, pending, stall_o, err_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter.
// Merges a single-cycle ALU result stream (no backpressure) with load results
// buffered in a small FIFO onto one registered register-file write port.
// ALU wins by default; a full queue starved for STARVE_LIMIT cycles forces a
// one-cycle upstream stall so the queue head can drain.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : wb_arbiter_if slave modport (alu_*, lsu_*, AD3/WE3/WD3,
//                pending, stall_o, err_o)
module wb_arbiter #(
    parameter int unsigned D_WIDTH      = 32,
    parameter int unsigned A_WIDTH      = 5,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);

    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW   = $clog2(DEPTH + 1);
    localparam int unsigned SW   = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned NREG = 2 ** A_WIDTH;

    typedef struct packed {
        logic [A_WIDTH-1:0] rd;
        logic [D_WIDTH-1:0] data;
    } entry_t;

    // Queue state
    entry_t [DEPTH-1:0]  mem_q, mem_d;
    logic   [DEPTH-1:0]  vld_q, vld_d;
    logic   [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic   [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic   [CW-1:0]     count_q, count_d;

    // Arbitration / status state
    logic   [SW-1:0]     starve_q, starve_d;
    logic                stall_q, stall_d;
    logic                err_q, err_d;

    // Register-file write port
    logic                we3_q, we3_d;
    logic   [A_WIDTH-1:0] ad3_q, ad3_d;
    logic   [D_WIDTH-1:0] wd3_q, wd3_d;

    logic                lsu_ready_c;
    logic                sel_alu_c;
    logic                pop_c;
    logic                push_c;
    logic   [SW-1:0]     starve_inc_c;
    logic   [NREG-1:0]   pending_c;
    entry_t              head_c;

    // Ready reflects current occupancy only; a same-cycle pop does not free a slot.
    assign lsu_ready_c = rst_n & (count_q < CW'(DEPTH));
    assign sel_alu_c   = bus.alu_valid & ~stall_q;
    assign pop_c       = ~sel_alu_c & (count_q != '0);
    assign push_c      = bus.lsu_valid & lsu_ready_c;
    assign head_c      = mem_q[rd_ptr_q];

    // Per-register hazard vector from the valid queue slots; r0 never pends.
    always_comb begin
        pending_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_q[PW'(i)] && (mem_q[PW'(i)].rd != '0)) begin
                pending_c[mem_q[PW'(i)].rd] = 1'b1;
            end
        end
        if (!rst_n) begin
            pending_c = '0;
        end
    end

    // Next-state: queue update, write-port selection, starvation and error tracking.
    always_comb begin
        mem_d        = mem_q;
        vld_d        = vld_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        starve_d     = starve_q;
        stall_d      = 1'b0;
        err_d        = err_q;
        we3_d        = 1'b0;
        ad3_d        = ad3_q;
        wd3_d        = wd3_q;
        starve_inc_c = '0;

        if (push_c) begin
            mem_d[wr_ptr_q].rd   = bus.lsu_rd;
            mem_d[wr_ptr_q].data = bus.lsu_data;
            vld_d[wr_ptr_q]      = 1'b1;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end

        if (pop_c) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PW'(1);
        end

        count_d = count_q + CW'(push_c) - CW'(pop_c);

        // Writes to r0 still consume the source but never assert the enable.
        if (sel_alu_c) begin
            ad3_d = bus.alu_rd;
            wd3_d = bus.alu_data;
            we3_d = (bus.alu_rd != '0);
        end else if (pop_c) begin
            ad3_d = head_c.rd;
            wd3_d = head_c.data;
            we3_d = (head_c.rd != '0);
        end

        // Count consecutive edges where a full queue lost to the ALU.
        if ((count_q == CW'(DEPTH)) && sel_alu_c) begin
            starve_inc_c = starve_q + SW'(1);
        end
        if (starve_inc_c == SW'(STARVE_LIMIT)) begin
            stall_d  = 1'b1;
            starve_d = '0;
        end else begin
            starve_d = starve_inc_c;
        end

        // An ALU result arriving during a stall cycle is dropped and flagged.
        if (bus.alu_valid && stall_q) begin
            err_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            err_q    <= 1'b0;
            we3_q    <= 1'b0;
            ad3_q    <= '0;
            wd3_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            err_q    <= err_d;
            we3_q    <= we3_d;
            ad3_q    <= ad3_d;
            wd3_q    <= wd3_d;
        end
    end

    assign bus.lsu_ready = lsu_ready_c;
    assign bus.pending   = pending_c;
    assign bus.WE3       = we3_q;
    assign bus.AD3       = ad3_q;
    assign bus.WD3       = wd3_q;
    assign bus.stall_o   = stall_q;
    assign bus.err_o     = err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (default parameters).
module tb_wb_arbiter;

    localparam int unsigned D_WIDTH = 32;
    localparam int unsigned A_WIDTH = 5;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    wb_arbiter_if #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH)) bus ();

    wb_arbiter #(
        .D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH), .DEPTH(2), .STARVE_LIMIT(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.lsu_valid = 1'b0;
        bus.lsu_rd    = '0;
        bus.lsu_data  = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        n_checks++; if (bus.WE3 !== 1'b0) begin n_fail++; $display("FAIL reset_we3 got %0b exp 0", bus.WE3); end
        n_checks++; if (bus.AD3 !== 5'd0) begin n_fail++; $display("FAIL reset_ad3 got %0d exp 0", bus.AD3); end
        n_checks++; if (bus.WD3 !== 32'd0) begin n_fail++; $display("FAIL reset_wd3 got %h exp 0", bus.WD3); end
        n_checks++; if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0b exp 0", bus.stall_o); end
        n_checks++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b exp 0", bus.err_o); end
        n_checks++; if (bus.lsu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %0b exp 0", bus.lsu_ready); end
        n_checks++; if (bus.pending !== 32'd0) begin n_fail++; $display("FAIL reset_pending got %h exp 0", bus.pending); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++; if (bus.lsu_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got %0b exp 1", bus.lsu_ready); end
    endtask

    task automatic test_alu_write();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234;
        tick();
        idle_inputs();
        n_checks++; if (bus.WE3 !== 1'b1) begin n_fail++; $display("FAIL alu_we3 got %0b exp 1", bus.WE3); end
        n_checks++; if (bus.AD3 !== 5'd5) begin n_fail++; $display("FAIL alu_ad3 got %0d exp 5", bus.AD3); end
        n_checks++; if (bus.WD3 !== 32'h1234) begin n_fail++; $display("FAIL alu_wd3 got %h exp 1234", bus.WD3); end
        tick();
        n_checks++; if (bus.WE3 !== 1'b0) begin n_fail++; $display("FAIL alu_idle_we3 got %0b exp 0", bus.WE3); end
        n_checks++; if (bus.AD3 !== 5'd5) begin n_fail++; $display("FAIL alu_hold_ad3 got %0d exp 5", bus.AD3); end
        n_checks++; if (bus.WD3 !== 32'h1234) begin n_fail++; $display("FAIL alu_hold_wd3 got %h exp 1234", bus.WD3); end
    endtask

    task automatic test_load_write();
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'hA5A5;
        tick();
        idle_inputs();
        n_checks++; if (bus.pending !== 32'h0000_0080) begin n_fail++; $display("FAIL load_pending got %h exp 00000080", bus.pending); end
        n_checks++; if (bus.WE3 !== 1'b0) begin n_fail++; $display("FAIL load_no_bypass got %0b exp 0", bus.WE3); end
        tick();
        n_checks++; if (bus.WE3 !== 1'b1) begin n_fail++; $display("FAIL load_we3 got %0b exp 1", bus.WE3); end
        n_checks++; if (bus.AD3 !== 5'd7) begin n_fail++; $display("FAIL load_ad3 got %0d exp 7", bus.AD3); end
        n_checks++; if (bus.WD3 !== 32'hA5A5) begin n_fail++; $display("FAIL load_wd3 got %h exp a5a5", bus.WD3); end
        n_checks++; if (bus.pending !== 32'd0) begin n_fail++; $display("FAIL load_pending_clr got %h exp 0", bus.pending); end
    endtask

    // Fill the queue with rd=3 then rd=4 (ALU busy on the second push so nothing drains),
    // then hold the ALU for four full-queue edges; leaves the bench in the stall cycle.
    task automatic fill_and_starve();
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd3; bus.lsu_data = 32'h3333;
        tick();
        bus.lsu_rd = 5'd4; bus.lsu_data = 32'h4444;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'hA0;
        tick();
        bus.lsu_valid = 1'b0;
        n_checks++; if (bus.lsu_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %0b exp 0", bus.lsu_ready); end
        n_checks++; if (bus.pending !== 32'h0000_0018) begin n_fail++; $display("FAIL full_pending got %h exp 00000018", bus.pending); end
        n_checks++; if (bus.AD3 !== 5'd10 || bus.WE3 !== 1'b1) begin n_fail++; $display("FAIL full_alu_write got ad3=%0d we3=%0b exp ad3=10 we3=1", bus.AD3, bus.WE3); end
        for (int i = 0; i < 4; i++) begin
            bus.alu_rd = 5'(11 + i); bus.alu_data = 32'(i);
            tick();
            n_checks++;
            if (bus.stall_o !== (i == 3)) begin n_fail++; $display("FAIL starve_stall_%0d got %0b exp %0b", i, bus.stall_o, (i == 3)); end
        end
        n_checks++; if (bus.AD3 !== 5'd14 || bus.WD3 !== 32'd3) begin n_fail++; $display("FAIL starve_alu_last got ad3=%0d wd3=%h exp ad3=14 wd3=3", bus.AD3, bus.WD3); end
        bus.alu_valid = 1'b0;
    endtask

    task automatic test_starve_drain();
        fill_and_starve();
        tick();
        n_checks++; if (bus.WE3 !== 1'b1 || bus.AD3 !== 5'd3 || bus.WD3 !== 32'h3333) begin n_fail++; $display("FAIL drain_head got we3=%0b ad3=%0d wd3=%h exp 1 3 3333", bus.WE3, bus.AD3, bus.WD3); end
        n_checks++; if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL drain_stall_one got %0b exp 0", bus.stall_o); end
        n_checks++; if (bus.lsu_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready got %0b exp 1", bus.lsu_ready); end
        n_checks++; if (bus.pending !== 32'h0000_0010) begin n_fail++; $display("FAIL drain_pending got %h exp 00000010", bus.pending); end
        tick();
        n_checks++; if (bus.WE3 !== 1'b1 || bus.AD3 !== 5'd4 || bus.WD3 !== 32'h4444) begin n_fail++; $display("FAIL drain_fifo got we3=%0b ad3=%0d wd3=%h exp 1 4 4444", bus.WE3, bus.AD3, bus.WD3); end
        n_checks++; if (bus.pending !== 32'd0) begin n_fail++; $display("FAIL drain_empty got %h exp 0", bus.pending); end
        n_checks++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL drain_err got %0b exp 0", bus.err_o); end
        tick();
    endtask

    task automatic test_rd_zero();
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'hDEAD;
        tick();
        idle_inputs();
        n_checks++; if (bus.pending !== 32'd0) begin n_fail++; $display("FAIL rd0_pending got %h exp 0", bus.pending); end
        tick();
        n_checks++; if (bus.WE3 !== 1'b0) begin n_fail++; $display("FAIL rd0_we3 got %0b exp 0", bus.WE3); end
        n_checks++; if (bus.AD3 !== 5'd0 || bus.WD3 !== 32'hDEAD) begin n_fail++; $display("FAIL rd0_consumed got ad3=%0d wd3=%h exp 0 dead", bus.AD3, bus.WD3); end
        tick();
        n_checks++; if (bus.WE3 !== 1'b0 || bus.WD3 !== 32'hDEAD) begin n_fail++; $display("FAIL rd0_no_repeat got we3=%0b wd3=%h exp 0 dead", bus.WE3, bus.WD3); end
    endtask

    task automatic test_stall_violation();
        fill_and_starve();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99;
        tick();
        idle_inputs();
        n_checks++; if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL err_set got %0b exp 1", bus.err_o); end
        n_checks++; if (bus.AD3 !== 5'd3 || bus.WD3 !== 32'h3333) begin n_fail++; $display("FAIL err_alu_dropped got ad3=%0d wd3=%h exp 3 3333", bus.AD3, bus.WD3); end
        tick();
        tick();
        n_checks++; if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %0b exp 1", bus.err_o); end
    endtask

    task automatic test_reset_mid();
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd6; bus.lsu_data = 32'h6666;
        tick();
        bus.lsu_rd = 5'd8; bus.lsu_data = 32'h8888;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd12; bus.alu_data = 32'hC;
        tick();
        idle_inputs();
        n_checks++; if (bus.pending !== 32'h0000_0140) begin n_fail++; $display("FAIL mid_pre_pending got %h exp 00000140", bus.pending); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.WE3 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_we3 got %0b exp 0", bus.WE3); end
        n_checks++; if (bus.pending !== 32'd0) begin n_fail++; $display("FAIL mid_rst_pending got %h exp 0", bus.pending); end
        n_checks++; if (bus.lsu_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready got %0b exp 0", bus.lsu_ready); end
        n_checks++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err got %0b exp 0", bus.err_o); end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (bus.WE3 !== 1'b0 || bus.pending !== 32'd0 || bus.lsu_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL mid_after_%0d got we3=%0b pending=%h ready=%0b exp 0 0 1", i, bus.WE3, bus.pending, bus.lsu_ready);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_alu_write();
        test_load_write();
        test_starve_drain();
        test_rd_zero();
        test_stall_violation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter D_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter A_WIDTH, default 5, register address width.
REQ-003 SHALL have parameter DEPTH, default 2, load-result queue entries (power of two, >=2).
REQ-004 SHALL have parameter STARVE_LIMIT, default 4, consecutive full-and-ALU-win cycles before a forced drain.
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-007 SHALL have port alu_valid  in  1  single-cycle ALU result present; there is no ready signal.
REQ-008 SHALL have port alu_rd  in  A_WIDTH  ALU destination register.
REQ-009 SHALL have port alu_data  in  D_WIDTH  ALU result.
REQ-010 SHALL have port lsu_valid  in  1  load result offered.
REQ-011 SHALL have port lsu_ready  out  1  queue accepts a load result this cycle.
REQ-012 SHALL have port lsu_rd  in  A_WIDTH  load destination register.
REQ-013 SHALL have port lsu_data  in  D_WIDTH  load result.
REQ-014 SHALL have port AD3  out  A_WIDTH  register-file write address, registered.
REQ-015 SHALL have port WE3  out  1  register-file write enable, registered.
REQ-016 SHALL have port WD3  out  D_WIDTH  register-file write data, registered.
REQ-017 SHALL have port pending  out  2**A_WIDTH  one bit per register with a queued load write, for hazard detection.
REQ-018 SHALL have port stall_o  out  1  upstream must not assert alu_valid next cycle, registered.
REQ-019 SHALL have port err_o  out  1  sticky protocol-violation flag.

Function
REQ-020 SHALL accept a load result (push) on a rising edge where lsu_valid=1 and lsu_ready=1.
REQ-021 SHALL drive lsu_ready = rst_n AND (count < DEPTH), using current occupancy only, with no same-cycle pop credit.
REQ-022 SHALL select the write source per edge: if stall_o=0 and alu_valid=1, select ALU; otherwise, if the queue is non-empty, select the head entry (pop); otherwise select no write.
REQ-023 SHALL, on the edge after selection, load AD3/WD3 with the selected rd/data and set WE3=1, except WE3=0 when the selected rd=0 (entry still consumed).
REQ-024 SHALL drive WE3=0 with AD3/WD3 holding their previous values when nothing is selected.
REQ-025 SHALL give ALU latency 1: alu_valid sampled at edge E produces WE3 during the cycle after E.
REQ-026 SHALL give load minimum latency 2: a push at E and a pop at E+1 produce WE3 after E+1; an empty queue provides no bypass.
REQ-027 SHALL update occupancy on a simultaneous push and pop as count+0, with wrap-around read/write pointers modulo DEPTH.
REQ-028 SHALL drain queue entries in FIFO order.
REQ-029 SHALL set pending[r]=1 iff any valid queue entry has rd=r, r!=0; pending[0] is always 0; duplicate rd entries are allowed.
REQ-030 SHALL increment the starve counter on each edge where count=DEPTH and the ALU is selected, and clear it on any other edge.
REQ-031 SHALL set stall_o=1 for exactly one cycle when the starve counter reaches STARVE_LIMIT, then clear the counter; during that cycle the head is popped.
REQ-032 SHALL, when alu_valid=1 while stall_o=1, drop the ALU result and set err_o=1 until reset.

Reset
REQ-033 SHALL, on rst_n low, asynchronously clear pointers, count, starve counter, WE3, AD3, WD3, stall_o and err_o to 0.
REQ-034 SHALL force lsu_ready=0 and pending=0 while rst_n is low; a queued entry is lost on mid-operation reset and is never written.
REQ-035 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Verification
REQ-036 SHALL cover: alu_valid=1, alu_rd=5, alu_data=0x1234 at edge E -> WE3=1, AD3=5, WD3=0x1234 after E; WE3=0 next cycle.
REQ-037 SHALL cover: lsu push rd=7, data=0xA5A5 at E with alu idle -> pending[7]=1 after E; WE3=1, AD3=7 after E+1; pending[7]=0.
REQ-038 SHALL cover: two pushes (rd=3, rd=4) fill DEPTH=2 -> lsu_ready=0; ALU held valid for 4 edges -> stall_o=1 for one cycle, rd=3 written; lsu_ready=1 again.
REQ-039 SHALL cover: push with lsu_rd=0 -> entry consumed, WE3 stays 0, pending stays 0.
REQ-040 SHALL cover: alu_valid=1 during stall_o=1 -> no ALU write, err_o=1 held until rst_n low.
REQ-041 SHALL cover: rst_n low mid-cycle with 2 queued entries -> immediate WE3=0, pending=0, lsu_ready=0; after release, queue empty and no stale writes.
